neigh_fifo: RTL and testbench



---
 rtl/neigh_fifo.sv | 75 +++++++
 tb/tb_neigh_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/neigh_fifo.sv
// Neighbour-link receive FIFO: first-word-fall-through queue feeding the PE
// operand selector, with occupancy count and sticky overflow/underflow flags.
module neigh_fifo #(
   parameter int LEN    = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [LEN-1:0]    wr_data,
   input  logic              rd_en,
   output logic [LEN-1:0]    rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              ovf_err,
   output logic              unf_err,
   input  logic              clr_err
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   logic [LEN-1:0]    mem [DEPTH];
   logic [ADDR_W-1:0] wp;
   logic [ADDR_W-1:0] rp;
   logic              push;
   logic              pop;
   logic              ovf_evt;
   logic              unf_evt;

   // Full/empty come from the count alone so wrap never confuses them.
   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);

   // A pop frees a slot in the same edge, so a full FIFO still takes a push.
   assign push    = wr_en && (!full || rd_en);
   assign pop     = rd_en && !empty;
   assign ovf_evt = wr_en && full && !rd_en;
   assign unf_evt = rd_en && empty;

   assign rd_data = empty ? '0 : mem[rp];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp      <= '0;
         rp      <= '0;
         count   <= '0;
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         // A new error event outranks a simultaneous clear.
         ovf_err <= (ovf_err && !clr_err) || ovf_evt;
         unf_err <= (unf_err && !clr_err) || unf_evt;
      end
   end

endmodule

// File: tb/tb_neigh_fifo.sv
// Directed self-checking bench for neigh_fifo: ordering, full/empty corner
// cases, sticky flags, pointer wrap and asynchronous reset.
module tb_neigh_fifo;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic       ovf_err;
   logic       unf_err;
   logic       clr_err;

   int n_cmp;
   int n_err;

   neigh_fifo #(.LEN(8), .DEPTH(4), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
      .count(count), .ovf_err(ovf_err), .unf_err(unf_err), .clr_err(clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      wr_data = 8'h00;
      idle();
      #2;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
      n_cmp++; if ({ovf_err, unf_err} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {ovf_err, unf_err}); end
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] vals [3];
      logic [7:0] exp_rd [3];
      logic [2:0] exp_cnt [3];
      vals    = '{8'h11, 8'h22, 8'h33};
      exp_rd  = '{8'h22, 8'h33, 8'h00};
      exp_cnt = '{3'd2, 3'd1, 3'd0};
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = vals[i];
         tick();
         n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL basic_push_count[%0d]: got %0d want %0d", i, count, i + 1); end
         n_cmp++; if (rd_data !== 8'h11) begin n_err++; $display("FAIL basic_head[%0d]: got %h want 11", i, rd_data); end
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         tick();
         n_cmp++; if (rd_data !== exp_rd[i]) begin n_err++; $display("FAIL basic_pop_data[%0d]: got %h want %h", i, rd_data, exp_rd[i]); end
         n_cmp++; if (count !== exp_cnt[i]) begin n_err++; $display("FAIL basic_pop_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]); end
      end
      idle();
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b want 1", empty); end
   endtask

   task automatic fill_a0();
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'hA0 + 8'(i);
         tick();
      end
      idle();
   endtask

   task automatic test_overflow();
      fill_a0();
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
      wr_en   = 1'b1;
      wr_data = 8'hFF;
      tick();
      idle();
      n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", count); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rd_data !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, rd_data, 8'hA0 + 8'(i)); end
         rd_en = 1'b1;
         tick();
      end
      idle();
      n_cmp++; if ({empty, rd_data} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL ovf_after_drain: got %b/%h want 1/00", empty, rd_data); end
      clr_err = 1'b1;
      tick();
      idle();
      n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf_err); end
   endtask

   task automatic test_full_rw();
      logic [7:0] exp_rd [4];
      exp_rd = '{8'hA1, 8'hA2, 8'hA3, 8'hB4};
      fill_a0();
      wr_en   = 1'b1;
      wr_data = 8'hB4;
      rd_en   = 1'b1;
      tick();
      idle();
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fullrw_count: got %0d want 4", count); end
      n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL fullrw_ovf: got %b want 0", ovf_err); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rd_data !== exp_rd[i]) begin n_err++; $display("FAIL fullrw_drain[%0d]: got %h want %h", i, rd_data, exp_rd[i]); end
         rd_en = 1'b1;
         tick();
      end
      idle();
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fullrw_empty: got %b want 1", empty); end
   endtask

   task automatic test_underflow();
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'h5C;
      #1;
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL unf_same_cycle: got %h want 00", rd_data); end
      tick();
      idle();
      n_cmp++; if (unf_err !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %b want 1", unf_err); end
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL unf_count: got %0d want 1", count); end
      n_cmp++; if (rd_data !== 8'h5C) begin n_err++; $display("FAIL unf_next: got %h want 5c", rd_data); end
      clr_err = 1'b1;
      tick();
      idle();
      n_cmp++; if (unf_err !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b want 0", unf_err); end
      rd_en = 1'b1;
      tick();
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL unf_drain: got %b want 1", empty); end
      clr_err = 1'b1;
      tick();
      idle();
      n_cmp++; if (unf_err !== 1'b1) begin n_err++; $display("FAIL unf_clear_vs_event: got %b want 1", unf_err); end
      clr_err = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_wrap();
      wr_en   = 1'b1;
      wr_data = 8'd1;
      tick();
      for (int k = 1; k < 10; k++) begin
         wr_data = 8'(k + 1);
         rd_en   = 1'b1;
         n_cmp++; if (rd_data !== 8'(k)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", k, rd_data, 8'(k)); end
         tick();
         n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, count); end
      end
      wr_en = 1'b0;
      n_cmp++; if (rd_data !== 8'd10) begin n_err++; $display("FAIL wrap_last: got %h want 0a", rd_data); end
      tick();
      idle();
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL wrap_end_count: got %0d want 0", count); end
      n_cmp++; if ({ovf_err, unf_err} !== 2'b00) begin n_err++; $display("FAIL wrap_flags: got %b want 00", {ovf_err, unf_err}); end
   endtask

   task automatic test_mid_reset();
      fill_a0();
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      idle();
      n_cmp++; if ({count, ovf_err} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL mrst_setup: got %0d/%b want 3/1", count, ovf_err); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mrst_empty: got %b want 1", empty); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL mrst_count: got %0d want 0", count); end
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL mrst_rd_data: got %h want 00", rd_data); end
      n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL mrst_ovf: got %b want 0", ovf_err); end
      #1 reset = 1'b0;
      wr_en   = 1'b1;
      wr_data = 8'h77;
      tick();
      idle();
      n_cmp++; if (rd_data !== 8'h77) begin n_err++; $display("FAIL mrst_push: got %h want 77", rd_data); end
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL mrst_push_count: got %0d want 1", count); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_full_rw();
      test_underflow();
      test_wrap();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
